// File: rtl/timed_flag_write_pkg.sv
// Shared types and helpers for the timed flag writer and its burst flusher.
package timed_flag_write_pkg;

  // Flush FSM encoding: read local memory, capture the word, present it on the databus.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_READ = 2'd1,
    ST_LOAD = 2'd2,
    ST_SEND = 2'd3
  } flush_state_t;

  // Entries that may be recorded per frame: the requested maximum, clamped to one
  // ping-pong half; zero also means a full half.
  function automatic logic [31:0] calc_limit(input logic [31:0] maximum,
                                             input int unsigned addr_w);
    logic [31:0] half;
    half = 32'(1) << (addr_w - 1);
    if ((maximum == 32'd0) || (maximum > half)) begin
      return half;
    end
    return maximum;
  endfunction

endpackage

// File: rtl/timed_flag_write_if.sv
// Write-burst databus between the timed flag writer and external memory.
interface timed_flag_write_if #(
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
);

  logic                    databus_ready_0;
  logic                    databus_valid_0;
  logic [AXI_ADDR_W-1:0]   databus_addr_0;
  logic [AXI_DATA_W-1:0]   databus_rdata_0;
  logic [AXI_DATA_W-1:0]   databus_wdata_0;
  logic [AXI_DATA_W/8-1:0] databus_wstrb_0;
  logic [LEN_W-1:0]        databus_len_0;
  logic                    databus_last_0;

  modport master (
    input  databus_ready_0,
    input  databus_rdata_0,
    input  databus_last_0,
    output databus_valid_0,
    output databus_addr_0,
    output databus_wdata_0,
    output databus_wstrb_0,
    output databus_len_0
  );

  modport slave (
    output databus_ready_0,
    output databus_rdata_0,
    output databus_last_0,
    input  databus_valid_0,
    input  databus_addr_0,
    input  databus_wdata_0,
    input  databus_wstrb_0,
    input  databus_len_0
  );

endinterface

// File: rtl/timed_flag_write_flag_burst_flusher.sv
// Streams the previous frame's timestamps out of local memory as one write burst.
//
// state   | meaning
// --------+-----------------------------------------------------------
// IDLE    | no flush in progress; waits for a launch with entries
// READ    | read strobe on port 1 at {flushed half, idx}
// LOAD    | read data arrives (1-cycle latency), captured into wdata
// SEND    | beat valid; addr/len/wdata held until ready
module flag_burst_flusher
  import timed_flag_write_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  disabled,
  input  logic [31:0]           flush_count,
  input  logic                  ping_pong,
  input  logic [AXI_DATA_W-1:0] rd_data,
  input  logic                  ready,
  input  logic                  last,
  output logic                  valid,
  output logic [AXI_DATA_W-1:0] wdata,
  output logic [LEN_W-1:0]      len,
  output logic [ADDR_W-1:0]     rd_addr,
  output logic                  rd_en,
  output logic                  busy
);

  flush_state_t state, state_nxt;

  logic [31:0]           idx;
  logic [31:0]           last_idx;
  logic [LEN_W-1:0]      len_q;
  logic [AXI_DATA_W-1:0] wdata_q;
  logic                  rd_half;

  logic go;
  logic beat_done;
  logic final_beat;

  assign go         = start && (flush_count != 32'd0) && !disabled;
  assign beat_done  = (state == ST_SEND) && ready;
  assign final_beat = last || (idx == last_idx);

  // State register; an async reset abandons any burst immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic: one beat per READ/LOAD/SEND round trip.
  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (go) state_nxt = ST_READ;
      ST_READ: state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_SEND;
      ST_SEND: if (ready) state_nxt = final_beat ? ST_IDLE : ST_READ;
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Output decode from the current state.
  always_comb begin
    valid = (state == ST_SEND);
    rd_en = (state == ST_READ);
    busy  = (state != ST_IDLE);
  end

  // Burst bookkeeping. The half and length are latched at launch so a run arriving
  // mid-flush cannot redirect or resize the burst already under way.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      idx      <= '0;
      last_idx <= '0;
      len_q    <= '0;
      wdata_q  <= '0;
      rd_half  <= 1'b0;
    end else begin
      if ((state == ST_IDLE) && go) begin
        idx      <= '0;
        last_idx <= flush_count - 32'd1;
        len_q    <= LEN_W'(flush_count - 32'd1);
        rd_half  <= ~ping_pong;
      end
      if (state == ST_LOAD) begin
        wdata_q <= rd_data;
      end
      if (beat_done) begin
        idx <= final_beat ? 32'd0 : idx + 32'd1;
      end
    end
  end

  assign wdata   = wdata_q;
  assign len     = len_q;
  assign rd_addr = {rd_half, idx[ADDR_W-2:0]};

endmodule

// File: rtl/timed_flag_write.sv
// Timestamps flag events into one ping-pong half per frame and flushes the
// previous frame's half to external memory as a single write burst.
module timed_flag_write
  import timed_flag_write_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int AXI_ADDR_W = 32,
  parameter int AXI_DATA_W = 32,
  parameter int LEN_W      = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  running,
  input  logic                  run,
  output logic                  done,
  timed_flag_write_if.master    bus,
  output logic [ADDR_W-1:0]     ext_dp_addr_0_port_0,
  output logic [AXI_DATA_W-1:0] ext_dp_out_0_port_0,
  input  logic [AXI_DATA_W-1:0] ext_dp_in_0_port_0,
  output logic                  ext_dp_enable_0_port_0,
  output logic                  ext_dp_write_0_port_0,
  output logic [ADDR_W-1:0]     ext_dp_addr_0_port_1,
  output logic [AXI_DATA_W-1:0] ext_dp_out_0_port_1,
  input  logic [AXI_DATA_W-1:0] ext_dp_in_0_port_1,
  output logic                  ext_dp_enable_0_port_1,
  output logic                  ext_dp_write_0_port_1,
  input  logic [AXI_ADDR_W-1:0] ext_addr,
  input  logic [31:0]           maximum,
  input  logic                  disabled,
  input  logic [31:0]           delay0,
  input  logic [31:0]           in0,
  output logic [31:0]           out0,
  output logic                  overflow
);

  // Largest burst the len field can describe.
  localparam logic [31:0] BURST_MAX = 32'(1) << LEN_W;

  logic                  ping_pong;
  logic [31:0]           delay;
  logic [31:0]           cycle;
  logic [31:0]           count;
  logic [31:0]           prev_count;
  logic [AXI_ADDR_W-1:0] base_addr;
  logic                  launch_req;

  logic [31:0] limit;
  logic [31:0] flush_count;
  logic        rec;
  logic        rec_ok;
  logic        rec_drop;
  logic        busy;
  logic        valid;
  logic        launch_trunc;
  logic        unused_inputs;

  assign limit        = calc_limit(maximum, ADDR_W);
  assign flush_count  = (prev_count > BURST_MAX) ? BURST_MAX : prev_count;
  assign rec          = running && (delay == 32'd0) && !disabled && (in0 != 32'd0);
  assign rec_ok       = rec && (count < limit);
  assign rec_drop     = rec && !rec_ok;
  assign launch_trunc = launch_req && !disabled && (prev_count > BURST_MAX);

  // Frame timing, recording and frame hand-off. A run while a flush is busy loses
  // the finished frame: its count and destination are not handed to the flusher.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ping_pong  <= 1'b0;
      delay      <= '0;
      cycle      <= '0;
      count      <= '0;
      prev_count <= '0;
      base_addr  <= '0;
      launch_req <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      launch_req <= run && !busy;
      if (run) begin
        ping_pong <= ~ping_pong;
        delay     <= delay0;
        cycle     <= '0;
        count     <= '0;
        if (!busy) begin
          prev_count <= count;
          base_addr  <= ext_addr;
        end else begin
          overflow <= 1'b1;
        end
      end else if (running) begin
        if (delay != 32'd0) begin
          delay <= delay - 32'd1;
        end else begin
          cycle <= cycle + 32'd1;
          if (rec_ok) begin
            count <= count + 32'd1;
          end
        end
      end
      if (rec_drop || launch_trunc) begin
        overflow <= 1'b1;
      end
    end
  end

  flag_burst_flusher #(
    .ADDR_W     (ADDR_W),
    .AXI_DATA_W (AXI_DATA_W),
    .LEN_W      (LEN_W)
  ) u_flusher (
    .clk         (clk),
    .rst         (rst),
    .start       (launch_req),
    .disabled    (disabled),
    .flush_count (flush_count),
    .ping_pong   (ping_pong),
    .rd_data     (ext_dp_in_0_port_1),
    .ready       (bus.databus_ready_0),
    .last        (bus.databus_last_0),
    .valid       (valid),
    .wdata       (bus.databus_wdata_0),
    .len         (bus.databus_len_0),
    .rd_addr     (ext_dp_addr_0_port_1),
    .rd_en       (ext_dp_enable_0_port_1),
    .busy        (busy)
  );

  assign bus.databus_valid_0 = valid;
  assign bus.databus_addr_0  = base_addr;
  assign bus.databus_wstrb_0 = valid ? '1 : '0;

  assign ext_dp_addr_0_port_0   = {ping_pong, count[ADDR_W-2:0]};
  assign ext_dp_out_0_port_0    = AXI_DATA_W'(cycle);
  assign ext_dp_enable_0_port_0 = rec_ok;
  assign ext_dp_write_0_port_0  = 1'b1;
  assign ext_dp_out_0_port_1    = '0;
  assign ext_dp_write_0_port_1  = 1'b0;

  assign out0 = count;
  assign done = (!running || disabled || !busy) && !valid;

  assign unused_inputs = ^{ext_dp_in_0_port_0, bus.databus_rdata_0};

endmodule

// File: tb/tb_timed_flag_write.sv
module tb_timed_flag_write;

  localparam int ADDR_W     = 16;
  localparam int AXI_ADDR_W = 32;
  localparam int AXI_DATA_W = 32;
  localparam int LEN_W      = 8;

  logic clk = 1'b0;
  logic rst;
  logic running, run, done, disabled, overflow;
  logic ready;
  logic [ADDR_W-1:0] p0_addr, p1_addr;
  logic [31:0] p0_out, p0_in, p1_out, p1_in;
  logic p0_en, p0_wr, p1_en, p1_wr;
  logic [31:0] ext_addr, maximum, delay0, in0, out0;
  logic [LEN_W-1:0] beat_n;

  always #5 clk = ~clk;

  timed_flag_write_if #(.AXI_ADDR_W(AXI_ADDR_W), .AXI_DATA_W(AXI_DATA_W), .LEN_W(LEN_W)) bus ();

  timed_flag_write #(.ADDR_W(ADDR_W), .AXI_ADDR_W(AXI_ADDR_W), .AXI_DATA_W(AXI_DATA_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .running(running), .run(run), .done(done), .bus(bus),
    .ext_dp_addr_0_port_0(p0_addr), .ext_dp_out_0_port_0(p0_out), .ext_dp_in_0_port_0(p0_in),
    .ext_dp_enable_0_port_0(p0_en), .ext_dp_write_0_port_0(p0_wr),
    .ext_dp_addr_0_port_1(p1_addr), .ext_dp_out_0_port_1(p1_out), .ext_dp_in_0_port_1(p1_in),
    .ext_dp_enable_0_port_1(p1_en), .ext_dp_write_0_port_1(p1_wr),
    .ext_addr(ext_addr), .maximum(maximum), .disabled(disabled), .delay0(delay0),
    .in0(in0), .out0(out0), .overflow(overflow));

  assign p0_in                = '0;
  assign bus.databus_ready_0  = ready;
  assign bus.databus_rdata_0  = '0;
  assign bus.databus_last_0   = bus.databus_valid_0 && (beat_n == bus.databus_len_0);

  // Local dual-port memory: write on port 0, 1-cycle registered read on port 1.
  logic [31:0] mem [0:(1<<ADDR_W)-1];
  always @(posedge clk) begin
    if (p0_en) mem[p0_addr] <= p0_out;
    if (p1_en) p1_in <= mem[p1_addr];
  end

  always @(posedge clk or posedge rst) begin
    if (rst) beat_n <= '0;
    else if (bus.databus_valid_0 && ready) beat_n <= bus.databus_last_0 ? '0 : beat_n + 1'b1;
  end

  typedef struct packed { logic [ADDR_W-1:0] addr; logic [31:0] data; } rec_t;
  typedef struct packed { logic [31:0] addr; logic [LEN_W-1:0] len; logic [31:0] data; } beat_t;

  rec_t  rec_q[$];
  beat_t beat_q[$];
  int checks = 0;
  int errors = 0;

  logic        ping_m;
  int          count_m;
  int          lim_m;
  logic [31:0] ts_cur[$];

  // Scoreboard: every port-0 write and every accepted beat is popped and compared.
  rec_t  got_r;
  beat_t got_b;
  always @(negedge clk) begin
    if (!rst && p0_en) begin
      checks++;
      if (rec_q.size() == 0) begin
        errors++;
        $display("FAIL rec_unexpected addr=%h data=%h required no write", p0_addr, p0_out);
      end else begin
        got_r = rec_q.pop_front();
        if ({p0_addr, p0_out} !== {got_r.addr, got_r.data}) begin
          errors++;
          $display("FAIL rec_write addr=%h data=%h required addr=%h data=%h",
                   p0_addr, p0_out, got_r.addr, got_r.data);
        end
      end
    end
    if (!rst && bus.databus_valid_0 && ready) begin
      checks++;
      if (beat_q.size() == 0) begin
        errors++;
        $display("FAIL beat_unexpected addr=%h data=%h required no beat",
                 bus.databus_addr_0, bus.databus_wdata_0);
      end else begin
        got_b = beat_q.pop_front();
        if ({bus.databus_addr_0, bus.databus_len_0, bus.databus_wdata_0, bus.databus_wstrb_0} !==
            {got_b.addr, got_b.len, got_b.data, 4'hF}) begin
          errors++;
          $display("FAIL beat addr=%h len=%0d data=%h strb=%h required addr=%h len=%0d data=%h strb=f",
                   bus.databus_addr_0, bus.databus_len_0, bus.databus_wdata_0, bus.databus_wstrb_0,
                   got_b.addr, got_b.len, got_b.data);
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tick(int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; run = 1'b0; in0 = '0; running = 1'b0; disabled = 1'b0;
    maximum = '0; delay0 = '0; ext_addr = '0; ready = 1'b1;
    rec_q.delete(); beat_q.delete(); ts_cur.delete();
    ping_m = 1'b0; count_m = 0; lim_m = 1 << (ADDR_W - 1);
    tick(3);
    rst = 1'b0;
    tick(1);
  endtask

  // Frame start pulse; when a flush is expected the finished frame's timestamps
  // become the expected beats of one burst to addr.
  task automatic do_run(logic [31:0] addr, int d0, bit expect_flush);
    beat_t b;
    run = 1'b1; ext_addr = addr; delay0 = d0;
    if (expect_flush) begin
      foreach (ts_cur[i]) begin
        b.addr = addr; b.len = LEN_W'(ts_cur.size() - 1); b.data = ts_cur[i];
        beat_q.push_back(b);
      end
    end
    ts_cur.delete(); count_m = 0; ping_m = ~ping_m;
    tick(1);
    run = 1'b0;
  endtask

  // Bit k of pattern raises in0 in timestamp cycle k; out0 is checked every cycle.
  task automatic play(logic [31:0] pattern, int n);
    rec_t r;
    for (int k = 0; k < n; k++) begin
      in0 = pattern[k] ? (32'h1 << k) : 32'h0;
      if (pattern[k] && count_m < lim_m) begin
        r.addr = {ping_m, 15'(count_m)}; r.data = k;
        rec_q.push_back(r); ts_cur.push_back(k); count_m++;
      end
      tick(1);
      checks++;
      if (out0 !== 32'(count_m)) begin
        errors++;
        $display("FAIL out0_step cycle=%0d got=%0d required=%0d", k, out0, count_m);
      end
    end
    in0 = '0;
  endtask

  task automatic wait_drain(int budget);
    for (int i = 0; i < budget; i++) begin
      if (beat_q.size() == 0 && !bus.databus_valid_0) break;
      tick(1);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; run = 1'b0; in0 = '0; running = 1'b1; ready = 1'b1;
    maximum = '0; delay0 = '0; ext_addr = 32'hFFFF_FFFF; disabled = 1'b0;
    tick(2);
    checks++;
    if ({bus.databus_valid_0, p0_en, p0_wr, p1_en, p1_wr, overflow} !== 6'b001000) begin
      errors++;
      $display("FAIL reset_ctrl valid=%b en0=%b wr0=%b en1=%b wr1=%b ovf=%b required 0 0 1 0 0 0",
               bus.databus_valid_0, p0_en, p0_wr, p1_en, p1_wr, overflow);
    end
    checks++;
    if ({out0, bus.databus_addr_0, bus.databus_len_0, bus.databus_wstrb_0, p1_addr, p0_addr} !== '0) begin
      errors++;
      $display("FAIL reset_data out0=%h addr=%h len=%h strb=%h a1=%h a0=%h required all 0",
               out0, bus.databus_addr_0, bus.databus_len_0, bus.databus_wstrb_0, p1_addr, p0_addr);
    end
  endtask

  task automatic test_record();
    do_reset();
    running = 1'b1;
    do_run(32'hA000_0000, 2, 1'b0);
    tick(2);
    play(32'h19, 6);
    checks++;
    if (rec_q.size() != 0) begin
      errors++;
      $display("FAIL record_missing got=%0d pending required 0", rec_q.size());
    end
    checks++;
    if (overflow !== 1'b0) begin
      errors++;
      $display("FAIL record_overflow got=%b required 0", overflow);
    end
  endtask

  // Follows test_record: flushes timestamps 0,3,4 from half 1.
  task automatic test_flush();
    int reads;
    logic half_exp;
    reads = 0;
    do_run(32'h1000_0040, 0, 1'b1);
    half_exp = ~ping_m;
    for (int i = 0; i < 60 && (beat_q.size() != 0 || bus.databus_valid_0); i++) begin
      if (p1_en) begin
        reads++;
        checks++;
        if (p1_addr[ADDR_W-1] !== half_exp) begin
          errors++;
          $display("FAIL flush_half got=%b required=%b", p1_addr[ADDR_W-1], half_exp);
        end
      end
      if (bus.databus_valid_0) begin
        checks++;
        if (done !== 1'b0) begin
          errors++;
          $display("FAIL flush_done_low got=%b required 0", done);
        end
      end
      tick(1);
    end
    checks++;
    if (beat_q.size() != 0 || reads != 3) begin
      errors++;
      $display("FAIL flush_complete pending=%0d reads=%0d required 0 pending 3 reads", beat_q.size(), reads);
    end
    tick(10);
    checks++;
    if (done !== 1'b1) begin
      errors++;
      $display("FAIL flush_done_after got=%b required 1", done);
    end
  endtask

  task automatic test_maximum();
    do_reset();
    running = 1'b1; maximum = 32'd2; lim_m = 2;
    do_run(32'h0, 1, 1'b0);
    tick(1);
    play(32'h15, 5);
    checks++;
    if ({out0, overflow} !== {32'd2, 1'b1}) begin
      errors++;
      $display("FAIL max_limit out0=%0d ovf=%b required out0=2 ovf=1", out0, overflow);
    end
    checks++;
    if (rec_q.size() != 0) begin
      errors++;
      $display("FAIL max_missing got=%0d pending required 0", rec_q.size());
    end
  endtask

  task automatic test_empty_frame();
    do_reset();
    running = 1'b1;
    do_run(32'h5000_0000, 0, 1'b0);
    tick(5);
    do_run(32'h6000_0000, 0, 1'b1);
    for (int i = 0; i < 20; i++) begin
      checks++;
      if ({bus.databus_valid_0, done} !== 2'b01) begin
        errors++;
        $display("FAIL empty_frame valid=%b done=%b required valid=0 done=1", bus.databus_valid_0, done);
      end
      tick(1);
    end
  endtask

  task automatic test_stall();
    int w;
    do_reset();
    running = 1'b1;
    do_run(32'h0, 0, 1'b0);
    play(32'h5, 3);
    ready = 1'b0;
    do_run(32'h2000_0000, 0, 1'b1);
    w = 0;
    while (!bus.databus_valid_0 && w < 20) begin tick(1); w++; end
    checks++;
    if (bus.databus_valid_0 !== 1'b1) begin
      errors++;
      $display("FAIL stall_valid_timeout got=%b required 1", bus.databus_valid_0);
    end
    for (int i = 0; i < 5; i++) begin
      checks++;
      if ({bus.databus_valid_0, bus.databus_addr_0, bus.databus_wdata_0, bus.databus_len_0} !==
          {1'b1, 32'h2000_0000, 32'd0, 8'd1}) begin
        errors++;
        $display("FAIL stall_hold valid=%b addr=%h data=%h len=%0d required 1 20000000 0 1",
                 bus.databus_valid_0, bus.databus_addr_0, bus.databus_wdata_0, bus.databus_len_0);
      end
      tick(1);
    end
    checks++;
    if (beat_q.size() != 2) begin
      errors++;
      $display("FAIL stall_advanced pending=%0d required 2", beat_q.size());
    end
    ready = 1'b1;
    wait_drain(40);
    checks++;
    if (beat_q.size() != 0) begin
      errors++;
      $display("FAIL stall_drain pending=%0d required 0", beat_q.size());
    end
  endtask

  task automatic test_run_mid_flush();
    do_reset();
    running = 1'b1;
    do_run(32'h0, 0, 1'b0);
    play(32'hF, 4);
    ready = 1'b0;
    do_run(32'h3000_0000, 0, 1'b1);
    play(32'h3, 2);
    tick(3);
    do_run(32'h4000_0000, 0, 1'b0);
    ready = 1'b1;
    wait_drain(60);
    checks++;
    if (beat_q.size() != 0) begin
      errors++;
      $display("FAIL midflush_drain pending=%0d required 0", beat_q.size());
    end
    for (int i = 0; i < 30; i++) begin
      checks++;
      if (bus.databus_valid_0 !== 1'b0) begin
        errors++;
        $display("FAIL midflush_second_burst valid=%b required 0", bus.databus_valid_0);
      end
      tick(1);
    end
    checks++;
    if (overflow !== 1'b1) begin
      errors++;
      $display("FAIL midflush_overflow got=%b required 1", overflow);
    end
  endtask

  initial begin
    test_reset();
    test_record();
    test_flush();
    test_maximum();
    test_empty_frame();
    test_stall();
    test_run_mid_flush();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
